divider_seq: RTL and testbench

- Sequential restoring divider; the inverse companion of the shift-add multiplier in the datapath.
- Driven by the same 6-bit Signal control bus. DIVU starts a division and OUT commits the result.
- Produces a 64-bit {remainder, quotient} word, arranged for the HI/LO register pair.
- One quotient bit per cycle. A busy/done handshake lets the controller sequence the OUT command.

---
 rtl/divider_seq.sv | 159 +++++++++++++++
 tb/tb_divider_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, driven by the Signal command bus.
// Define DIVIDER_SIGNED_EN to also accept the signed DIV command.
module divider_seq #(
  parameter int unsigned WIDTH = 32,
  parameter logic [5:0]  DIVU  = 6'd27,
  parameter logic [5:0]  OUT   = 6'b111111
`ifdef DIVIDER_SIGNED_EN
  ,
  parameter logic [5:0]  DIV   = 6'd26
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic                 dz_q, dz_d;

  logic                 start;
  logic [WIDTH-1:0]     op_a, op_b;
  logic [WIDTH:0]       shifted;
  logic                 ge;
  logic [WIDTH-1:0]     step_rem, step_quo;

`ifdef DIVIDER_SIGNED_EN
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 start_s;

  always_comb begin
    start_s = (Signal == DIV);
    start   = (Signal == DIVU) || start_s;
    op_a    = (start_s && dataA[WIDTH-1]) ? -dataA : dataA;
    op_b    = (start_s && dataB[WIDTH-1]) ? -dataB : dataB;
  end
`else
  always_comb begin
    start = (Signal == DIVU);
    op_a  = dataA;
    op_b  = dataB;
  end
`endif

  // WIDTH+1-bit compare keeps divisors >= 2^(WIDTH-1) from overflowing.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvsr_q});
    step_rem = ge ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dz_d    = dz_q;
`ifdef DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (dataB == '0) begin
            dz_d    = 1'b1;
            rem_d   = dataA;
            quo_d   = '1;
            dvsr_d  = '0;
            state_d = StDone;
          end else begin
            dz_d    = 1'b0;
            rem_d   = '0;
            quo_d   = op_a;
            dvsr_d  = op_b;
            state_d = StRun;
`ifdef DIVIDER_SIGNED_EN
            qneg_d  = start_s && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            rneg_d  = start_s && dataA[WIDTH-1];
`endif
          end
        end
      end
      StRun: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
`ifdef DIVIDER_SIGNED_EN
          // Sign fix-up folds into the last step so latency is unchanged.
          quo_d = qneg_q ? -step_quo : step_quo;
          rem_d = rneg_q ? -step_rem : step_rem;
`endif
        end
      end
      StDone: begin
        if (Signal == OUT) begin
          out_d   = {rem_q, quo_q};
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      dz_q    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dz_q    <= dz_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign dataOut  = out_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed, table-driven bench for divider_seq with hand-written multi-cycle corner sequences.
module tb_divider_seq;

  localparam logic [5:0] CmdDivu = 6'd27;
  localparam logic [5:0] CmdOut  = 6'b111111;
  localparam logic [5:0] CmdDiv  = 6'd26;
  localparam logic [5:0] CmdNop  = 6'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = CmdNop;
  logic [63:0] dataOut;
  logic        busy, done, div_zero;

  int tests = 0;
  int failed = 0;
  logic [63:0] prev_out = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    logic        dz;
  } vec_t;

  vec_t vecs [9];

  divider_seq dut (
    .clk      (clk),
    .reset    (reset),
    .dataA    (dataA),
    .dataB    (dataB),
    .Signal   (Signal),
    .dataOut  (dataOut),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue a divide command, wait for done, verify latency/flags, then commit with OUT.
  task automatic run_div(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic dz, input string name);
    int ext;
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = code;
    @(negedge clk);
    Signal = CmdNop;
    dataA  = 32'hDEAD_BEEF;
    dataB  = 32'h0000_0003;
    ext    = 0;
    if (!dz) check({name, " busy"}, 64'(busy), 64'd1);
    while (!done && ext < 100) begin
      @(negedge clk);
      ext++;
    end
    check({name, " latency"}, 64'(ext), dz ? 64'd0 : 64'd32);
    check({name, " div_zero"}, 64'(div_zero), 64'(dz));
    check({name, " busy in done"}, 64'(busy), 64'd0);
    check({name, " out held"}, dataOut, prev_out);
    Signal = CmdOut;
    @(negedge clk);
    Signal = CmdNop;
    check({name, " dataOut"}, dataOut, exp);
    check({name, " done clear"}, 64'(done), 64'd0);
    prev_out = exp;
  endtask

  initial begin
    int ext;
    vecs[0] = '{a: 32'd100,        b: 32'd7,          exp: 64'h00000002_0000000E, dz: 1'b0};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'h80000000,   exp: 64'h7FFFFFFF_00000001, dz: 1'b0};
    vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'd1,          exp: 64'h00000000_FFFFFFFF, dz: 1'b0};
    vecs[3] = '{a: 32'd5,          b: 32'd0,          exp: 64'h00000005_FFFFFFFF, dz: 1'b1};
    vecs[4] = '{a: 32'd9,          b: 32'd3,          exp: 64'h00000000_00000003, dz: 1'b0};
    vecs[5] = '{a: 32'd0,          b: 32'd5,          exp: 64'h00000000_00000000, dz: 1'b0};
    vecs[6] = '{a: 32'd7,          b: 32'd9,          exp: 64'h00000007_00000000, dz: 1'b0};
    vecs[7] = '{a: 32'd1000000,    b: 32'd1000,       exp: 64'h00000000_000003E8, dz: 1'b0};
    vecs[8] = '{a: 32'h12345678,   b: 32'h00000010,   exp: 64'h00000008_01234567, dz: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset dataOut", dataOut, 64'd0);
    reset = 1'b1;

    // OUT in IDLE must not touch dataOut
    @(negedge clk);
    Signal = CmdOut;
    @(negedge clk);
    Signal = CmdNop;
    check("idle OUT dataOut", dataOut, 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_div(CmdDivu, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dz, $sformatf("vec%0d", i));
    end

    // DIVU and OUT during RUN are ignored; DIVU during DONE is ignored
    @(negedge clk);
    dataA  = 32'd100;
    dataB  = 32'd7;
    Signal = CmdDivu;
    @(negedge clk);
    Signal = CmdNop;
    ext = 0;
    repeat (3) begin
      @(negedge clk);
      ext++;
    end
    dataA  = 32'd50;
    dataB  = 32'd5;
    Signal = CmdDivu;
    @(negedge clk);
    ext++;
    Signal = CmdOut;
    @(negedge clk);
    ext++;
    Signal = CmdNop;
    check("ign out held in run", dataOut, prev_out);
    check("ign still busy", 64'(busy), 64'd1);
    while (!done && ext < 100) begin
      @(negedge clk);
      ext++;
    end
    check("ign latency", 64'(ext), 64'd32);
    dataA  = 32'd9;
    dataB  = 32'd0;
    Signal = CmdDivu;
    @(negedge clk);
    Signal = CmdNop;
    check("ign DIVU in done", 64'(done), 64'd1);
    check("ign div_zero", 64'(div_zero), 64'd0);
    Signal = CmdOut;
    @(negedge clk);
    Signal = CmdNop;
    check("ign dataOut", dataOut, 64'h00000002_0000000E);
    prev_out = 64'h00000002_0000000E;

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    dataA  = 32'hFFFFFFFF;
    dataB  = 32'd3;
    Signal = CmdDivu;
    @(negedge clk);
    Signal = CmdNop;
    repeat (10) @(negedge clk);
    check("mid busy before reset", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset dataOut", dataOut, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    prev_out = '0;
    run_div(CmdDivu, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, "post reset");

`ifdef DIVIDER_SIGNED_EN
    run_div(CmdDiv, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "signed -7/2");
    run_div(CmdDiv, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, "signed min/-1");
    run_div(CmdDiv, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1, "signed zero");
`else
    // DIV is an unrecognised code in the unsigned build
    @(negedge clk);
    dataA  = 32'd10;
    dataB  = 32'd2;
    Signal = CmdDiv;
    @(negedge clk);
    Signal = CmdNop;
    check("DIV ignored busy", 64'(busy), 64'd0);
    check("DIV ignored done", 64'(done), 64'd0);
    @(negedge clk);
    check("DIV ignored dataOut", dataOut, prev_out);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
